// File: rtl/bus_dec_pkg.sv
// Shared types and constants for the bus decoder: widths, FSM states,
// error kinds and the board memory map as word-address base/mask pairs.
package bus_dec_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  typedef enum logic {
    ERR_UNMAPPED = 1'b0,
    ERR_TIMEOUT  = 1'b1
  } err_kind_t;

  // Board map, word addresses (byte address >> 2); mask bit 1 = compared.
  localparam logic [ADDR_W-1:0] PROM_BASE = 22'h3FF800;  // 0xFFE000, 4 KB
  localparam logic [ADDR_W-1:0] PROM_MASK = 22'h3FFC00;
  localparam logic [ADDR_W-1:0] RAM_BASE  = 22'h000000;  // 0x000000, 1 MB
  localparam logic [ADDR_W-1:0] RAM_MASK  = 22'h3C0000;
  localparam logic [ADDR_W-1:0] VID_BASE  = 22'h040000;  // 0x100000, 128 KB
  localparam logic [ADDR_W-1:0] VID_MASK  = 22'h3F8000;
  localparam logic [ADDR_W-1:0] IO_BASE   = 22'h3FFFF0;  // 0xFFFFC0, 64 B
  localparam logic [ADDR_W-1:0] IO_MASK   = 22'h3FFFF0;
  localparam logic [ADDR_W-1:0] XIO_BASE  = 22'h3FFFE0;  // 0xFFFF80, 64 B
  localparam logic [ADDR_W-1:0] XIO_MASK  = 22'h3FFFF0;

  localparam int MAP_NUM_SLV = 5;
  localparam logic [MAP_NUM_SLV*ADDR_W-1:0] MAP_SLV_BASE =
    {XIO_BASE, IO_BASE, VID_BASE, RAM_BASE, PROM_BASE};
  localparam logic [MAP_NUM_SLV*ADDR_W-1:0] MAP_SLV_MASK =
    {XIO_MASK, IO_MASK, VID_MASK, RAM_MASK, PROM_MASK};

  function automatic logic addr_match(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] mask);
    return ((addr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/bus_dec_if.sv
// CPU-side bus between the master and the address decoder.
interface bus_dec_if;
  import bus_dec_pkg::*;

  logic              bus_stb;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_din;
  logic              bus_ack;

  modport master (
    output bus_stb, bus_we, bus_addr,
    input  bus_din, bus_ack
  );

  modport slave (
    input  bus_stb, bus_we, bus_addr,
    output bus_din, bus_ack
  );

endinterface

// File: rtl/bus_dec_tmo.sv
// Access timer: counts cycles of an outstanding strobe, saturating at
// all-ones, and flags when the count equals TIMEOUT.
module bus_tmo
  import bus_dec_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic done,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || done) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(1);
    end else if (run && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/bus_dec.sv
// Address decoder and response mux with unmapped/timeout error termination
// and first-fault capture.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no access outstanding, waiting for a strobe
//   BUSY   | mapped access outstanding, timer counting
//   ERR    | one-cycle forced ack (data 0), error captured on exit
module bus_dec
  import bus_dec_pkg::*;
#(
  parameter int                         NUM_SLV  = 9,
  parameter int                         TIMEOUT  = 255,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_MASK = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  bus_dec_if.slave                  cpu,
  output logic [NUM_SLV-1:0]        slv_stb,
  input  logic [NUM_SLV*DATA_W-1:0] slv_dout,
  input  logic [NUM_SLV-1:0]        slv_ack,
  input  logic                      err_clr,
  output logic                      err_valid,
  output logic                      err_kind,
  output logic                      err_we,
  output logic [ADDR_W-1:0]         err_addr,
  output logic                      err_ovf
);

  logic [NUM_SLV-1:0] win_sel;
  logic               win_vld;
  logic               win_ack;
  logic [DATA_W-1:0]  win_dout;

  state_t    state, state_nxt;
  err_kind_t pend_kind, kind_nxt;
  logic      tmo_start, tmo_run, tmo_done, tmo_expired;
  logic      capture;
  logic      force_ack;

  // Lowest-index hit wins; everything downstream keys off the one-hot select.
  always_comb begin
    win_sel  = '0;
    win_vld  = 1'b0;
    win_ack  = 1'b0;
    win_dout = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!win_vld && cpu.bus_stb &&
          addr_match(cpu.bus_addr, SLV_BASE[i*ADDR_W +: ADDR_W],
                     SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        win_vld    = 1'b1;
        win_sel[i] = 1'b1;
        win_ack    = slv_ack[i];
        win_dout   = slv_dout[i*DATA_W +: DATA_W];
      end
    end
  end

  assign slv_stb = win_sel;

  // The forced ack is suppressed during reset so an aborted access never
  // completes with an error.
  assign force_ack   = (state == S_ERR) && !rst;
  assign cpu.bus_ack = win_ack | force_ack;
  assign cpu.bus_din = force_ack ? '0 : win_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pend_kind <= ERR_UNMAPPED;
    end else begin
      state     <= state_nxt;
      pend_kind <= kind_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    kind_nxt  = pend_kind;
    tmo_start = 1'b0;
    tmo_run   = 1'b0;
    tmo_done  = 1'b0;
    capture   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpu.bus_stb) begin
          if (win_vld) begin
            state_nxt = S_BUSY;
            tmo_start = 1'b1;
          end else begin
            state_nxt = S_ERR;
            kind_nxt  = ERR_UNMAPPED;
          end
        end
      end
      S_BUSY: begin
        // A slave ack beats an expiring timer in the same cycle.
        if (win_ack) begin
          if (cpu.bus_stb) begin
            tmo_start = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            tmo_done  = 1'b1;
          end
        end else if (!cpu.bus_stb) begin
          state_nxt = S_IDLE;
          tmo_done  = 1'b1;
        end else if (!win_vld) begin
          // Back-to-back access that moved to an unmapped address.
          state_nxt = S_ERR;
          kind_nxt  = ERR_UNMAPPED;
          tmo_done  = 1'b1;
        end else if (tmo_expired) begin
          state_nxt = S_ERR;
          kind_nxt  = ERR_TIMEOUT;
          tmo_done  = 1'b1;
        end else begin
          tmo_run = 1'b1;
        end
      end
      S_ERR: begin
        state_nxt = S_IDLE;
        capture   = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        tmo_done  = 1'b1;
      end
    endcase
  end

  bus_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .start   (tmo_start),
    .run     (tmo_run),
    .done    (tmo_done),
    .expired (tmo_expired)
  );

  // First fault is held for software; a clear arriving with a new fault
  // makes the new fault the first one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_kind  <= 1'b0;
      err_we    <= 1'b0;
      err_addr  <= '0;
      err_ovf   <= 1'b0;
    end else if (capture) begin
      if (!err_valid || err_clr) begin
        err_valid <= 1'b1;
        err_kind  <= pend_kind;
        err_we    <= cpu.bus_we;
        err_addr  <= cpu.bus_addr;
        err_ovf   <= 1'b0;
      end else begin
        err_ovf <= 1'b1;
      end
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_dec.sv
// Randomized transaction-level bench for bus_dec against a decode/error
// model built from the address map and access-timing rules.
module tb_bus_dec;
  import bus_dec_pkg::*;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [21:0] B0 = 22'h000000, M0 = 22'h3FF000;
  localparam logic [21:0] B1 = 22'h000100, M1 = 22'h3FFF00;
  localparam logic [21:0] B2 = 22'h3FFFF0, M2 = 22'h3FFFF0;
  localparam logic [21:0] B3 = 22'h200000, M3 = 22'h300000;
  localparam logic [NS*22-1:0] P_BASE = {B3, B2, B1, B0};
  localparam logic [NS*22-1:0] P_MASK = {M3, M2, M1, M0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_dec_if u_if ();

  logic [NS-1:0]    slv_stb;
  logic [NS*32-1:0] slv_dout;
  logic [NS-1:0]    slv_ack;
  logic             err_clr;
  logic             err_valid, err_kind, err_we, err_ovf;
  logic [21:0]      err_addr;

  bus_dec #(
    .NUM_SLV  (NS),
    .TIMEOUT  (TMO),
    .SLV_BASE (P_BASE),
    .SLV_MASK (P_MASK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (u_if),
    .slv_stb   (slv_stb),
    .slv_dout  (slv_dout),
    .slv_ack   (slv_ack),
    .err_clr   (err_clr),
    .err_valid (err_valid),
    .err_kind  (err_kind),
    .err_we    (err_we),
    .err_addr  (err_addr),
    .err_ovf   (err_ovf)
  );

  logic [21:0] base_a [NS];
  logic [21:0] mask_a [NS];
  logic [31:0] slv_data [NS];

  logic        m_valid, m_kind, m_we, m_ovf;
  logic [21:0] m_addr;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_decode(input logic [21:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_a[i]) == (base_a[i] & mask_a[i])) return i;
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < NS; i++) slv_data[i] = $urandom;
  endtask

  task automatic model_update(input logic is_err, input logic kind, input logic we,
                              input logic [21:0] addr, input logic clr);
    if (is_err) begin
      if (!m_valid || clr) begin
        m_valid = 1'b1; m_kind = kind; m_we = we; m_addr = addr; m_ovf = 1'b0;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (clr) begin
      m_valid = 1'b0; m_ovf = 1'b0;
    end
  endtask

  task automatic check_err(input string tag);
    check({tag, "_valid"}, err_valid, m_valid);
    check({tag, "_kind"},  err_kind,  m_kind);
    check({tag, "_we"},    err_we,    m_we);
    check({tag, "_addr"},  err_addr,  m_addr);
    check({tag, "_ovf"},   err_ovf,   m_ovf);
  endtask

  // d = cycle (0 = strobe cycle) in which the addressed slave acks.
  task automatic do_txn(input logic [21:0] a, input logic we, input int d,
                        input bit clr_ack, input bit clr_gap);
    int          w, exp_cyc, ack_k;
    logic        exp_err, exp_kind;
    logic [31:0] exp_din;
    logic [NS-1:0] exp_stb;
    bit          got;
    w = ref_decode(a);
    exp_stb = (w < 0) ? '0 : NS'(1) << w;
    if (w < 0) begin
      exp_cyc = 1; exp_err = 1'b1; exp_kind = 1'b0; exp_din = '0;
    end else if (d <= TMO) begin
      exp_cyc = d; exp_err = 1'b0; exp_kind = 1'b0; exp_din = slv_data[w];
    end else begin
      exp_cyc = TMO + 1; exp_err = 1'b1; exp_kind = 1'b1; exp_din = '0;
    end
    got = 1'b0;
    ack_k = -1;
    for (int k = 0; k <= TMO + 4 && !got; k++) begin
      @(negedge clk);
      u_if.bus_stb  = 1'b1;
      u_if.bus_we   = we;
      u_if.bus_addr = a;
      for (int i = 0; i < NS; i++) begin
        slv_dout[i*32 +: 32] = slv_data[i];
        slv_ack[i] = (i == w) ? (k == d) : 1'($urandom_range(0, 1));
      end
      err_clr = clr_ack && (k == exp_cyc);
      #1;
      if (k == 0) check("stb_sel", 32'(slv_stb), 32'(exp_stb));
      if (u_if.bus_ack) begin
        got = 1'b1;
        ack_k = k;
        check("ack_cycle", ack_k, exp_cyc);
        check("ack_din", u_if.bus_din, exp_din);
        check("ack_stb", 32'(slv_stb), 32'(exp_stb));
      end
    end
    if (!got) check("ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    u_if.bus_stb = 1'b0;
    slv_ack = '0;
    err_clr = clr_gap;
    model_update(exp_err, exp_kind, we, a, clr_ack);
    #1;
    check("gap_ack", u_if.bus_ack, 1'b0);
    check_err("err");
    model_update(1'b0, 1'b0, 1'b0, '0, clr_gap);
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [21:0] a;
    int          d, sel, si;
    bit          seen;
    base_a = '{B0, B1, B2, B3};
    mask_a = '{M0, M1, M2, M3};
    u_if.bus_stb = 1'b0; u_if.bus_we = 1'b0; u_if.bus_addr = '0;
    slv_ack = '0; slv_dout = '0; err_clr = 1'b0;
    m_valid = 1'b0; m_kind = 1'b0; m_we = 1'b0; m_addr = '0; m_ovf = 1'b0;

    // Combinational paths stay live during reset.
    @(negedge clk);
    u_if.bus_stb = 1'b1; u_if.bus_addr = 22'h3FFFF1;
    slv_ack = 4'b0100; slv_dout[2*32 +: 32] = 32'h12345678;
    #1;
    check("rst_stb", 32'(slv_stb), 32'h4);
    check("rst_ack", u_if.bus_ack, 1'b1);
    check("rst_din", u_if.bus_din, 32'h12345678);
    @(negedge clk);
    u_if.bus_stb = 1'b0; slv_ack = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_ack", u_if.bus_ack, 1'b0);
    check_err("reset");

    rand_data(); slv_data[2] = 32'hDEADBEEF;
    do_txn(22'h3FFFF1, 1'b0, 3, 1'b0, 1'b0);
    rand_data();
    do_txn(22'h000100, 1'b0, 2, 1'b0, 1'b0);
    rand_data();
    do_txn(22'h3FFF00, 1'b1, 0, 1'b0, 1'b0);
    rand_data();
    do_txn(22'h212345, 1'b0, 255, 1'b0, 1'b0);
    rand_data();
    do_txn(22'h0F0000, 1'b1, 0, 1'b1, 1'b0);
    rand_data();
    do_txn(22'h000010, 1'b0, 1, 1'b0, 1'b1);
    rand_data();
    do_txn(22'h2ABCDE, 1'b1, 255, 1'b0, 1'b1);
    rand_data();
    do_txn(22'h2ABCDF, 1'b0, TMO, 1'b0, 1'b0);
    rand_data();
    do_txn(22'h2000F0, 1'b0, TMO + 1, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      rand_data();
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        si = $urandom_range(0, NS - 1);
        a = (base_a[si] & mask_a[si]) | (22'($urandom) & ~mask_a[si]);
      end else begin
        a = 22'($urandom);
      end
      d = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, TMO + 1);
      do_txn(a, 1'($urandom_range(0, 1)), d,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a mapped access that is never acked.
    rand_data();
    do_txn(22'h3FFF00, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      u_if.bus_stb = 1'b1; u_if.bus_we = 1'b0; u_if.bus_addr = 22'h2000AA;
      slv_ack = '0;
      if (k == 5) begin
        rst = 1'b1;
        #1;
        check("busy_rst_ack", u_if.bus_ack, 1'b0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    u_if.bus_stb = 1'b0;
    m_valid = 1'b0; m_kind = 1'b0; m_we = 1'b0; m_addr = '0; m_ovf = 1'b0;
    #1;
    check_err("busy_rst");
    seen = 1'b0;
    repeat (TMO + 10) begin
      @(negedge clk);
      #1;
      if (u_if.bus_ack || err_valid) seen = 1'b1;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
